fetch_controller: RTL and testbench
===================================

# fetch_controller

Fetch-stage sequencer for the pipelined processor's instruction memory, which is 256 × 20-bit with a combinational read port. It owns the program counter and drives the memory address. It presents a registered instruction/PC pair to decode, and handles stall, branch redirect and halt detection. It also time-shares the memory address port with a program-load path that writes instructions over a valid/ready stream before execution starts.

## Interface
- DATA_WIDTH, 20, instruction width
- ADDRESS_WIDTH, 8, memory address width
- MEM_SIZE, 256, memory depth; must equal 2**ADDRESS_WIDTH
- HALT_WORD, 20'hFFFFF, instruction encoding that stops fetch

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  request to enter program-load mode
- run_start  in  1  request to start execution at address 0
- load_valid  in  1  load beat valid
- load_data  in  DATA_WIDTH  instruction word to store
- load_last  in  1  final beat of program
- load_ready  out  1  load beat accepted when high with load_valid
- stall  in  1  decode back-pressure; hold fetch outputs
- branch_taken  in  1  redirect fetch
- branch_target  in  ADDRESS_WIDTH  redirect address
- imem_addr  out  ADDRESS_WIDTH  memory address (read or write)
- imem_rdata  in  DATA_WIDTH  combinational read data for imem_addr
- imem_we  out  1  memory write enable
- imem_wdata  out  DATA_WIDTH  memory write data
- if_instr  out  DATA_WIDTH  fetched instruction to decode
- if_pc  out  ADDRESS_WIDTH  address of if_instr
- if_valid  out  1  if_instr/if_pc valid
- state  out  2  IDLE=00, LOAD=01, RUN=10, HALT=11
- halted  out  1  high in HALT
- load_count  out  ADDRESS_WIDTH+1  words written in last load (0..MEM_SIZE)

## Operation
- Reset (asynchronous, any state): state=IDLE, pc=0, wr_ptr=0, load_count=0, if_instr=0, if_pc=0, if_valid=0. Combinational outputs: halted=0, load_ready=0, imem_we=0, imem_addr=0, imem_wdata=0.
- IDLE
  - imem_addr=0.
  - load_start → LOAD, with wr_ptr=0 and load_count=0.
  - Otherwise run_start → RUN, with pc=0.
  - If both are asserted, load_start wins.
- LOAD
  - load_ready=1, imem_addr=wr_ptr, imem_wdata=load_data.
  - imem_we = load_valid & load_ready, combinationally.
  - Each accepted beat: wr_ptr+1, load_count+1.
  - Accepted beat with load_last, or accepted beat at wr_ptr=MEM_SIZE-1 (memory full): → IDLE. load_ready is low from the next cycle.
  - run_start, stall and branch inputs are ignored. if_valid=0.
- RUN
  - imem_addr=pc; imem_we=0.
  - Priority per cycle: branch_taken > stall > normal fetch.
  - branch_taken: pc←branch_target, if_valid←0 (bubble). Halt check is suppressed.
  - stall (no branch): pc, if_instr, if_pc, if_valid hold.
  - Normal fetch, imem_rdata≠HALT_WORD: if_instr←imem_rdata, if_pc←pc, if_valid←1, pc←pc+1. pc wraps from MEM_SIZE-1 to 0.
  - Normal fetch, imem_rdata=HALT_WORD: → HALT, if_valid←0, pc holds at the halt address. HALT_WORD is never issued to decode.
- HALT
  - halted=1, imem_addr=pc, if_valid=0.
  - load_start → LOAD; run_start → RUN with pc=0; load_start wins if both.

## Timing
- Fetch latency: 1 cycle. The instruction at pc in cycle N appears on if_instr/if_valid in cycle N+1.
- Throughput: 1 instruction/cycle when unstalled.
- Branch sampled in cycle N:
  - N+1: if_valid=0, pc=target.
  - N+2: if_instr=mem[target], if_valid=1 (absent stall).
- Stall: outputs are frozen on the cycle after the stall is sampled. Release resumes from the same pc with no skipped or duplicated instruction.
- Load: the write occurs in the handshake cycle. The first beat can be accepted the cycle after load_start is sampled.
- Halt: HALT_WORD is seen on imem_rdata in cycle N; state=HALT and if_valid=0 in N+1.
- Reset mid-load: a partially written program remains in memory; load_count=0.

## Test plan
- Load: reset, load_start, 4 beats 0x00011/0x00022/0x00033/0xFFFFF with load_last on the 4th → 4 writes to addresses 0..3, load_count=4, state returns to IDLE, load_ready=0.
- Run after that load: run_start → if_instr 0x00011, 0x00022, 0x00033 on consecutive cycles with if_pc 0,1,2. Then if_valid=0, halted=1, state=HALT, pc=3.
- Stall: stall high for 3 cycles after the first fetch → if_instr=0x00011 and if_pc=0 held for 3 cycles, then 0x00022 with no gap.
- Branch: branch_taken with branch_target=0x40 while mem[0x40]=0x0ABCD and stall=1 → 1 bubble cycle, then if_instr=0x0ABCD, if_pc=0x40 (branch overrides stall).
- Full load: 256 beats without load_last → the 256th beat is written to 0xFF, load_count=256, then IDLE and load_ready=0. A program with no halt wraps pc from 0xFF to 0x00.
- Async reset asserted mid-RUN and mid-LOAD → all outputs return to their reset values immediately, with no imem_we pulse.

Source files
------------

// File: rtl/fetch_controller.sv
// fetch_controller
// Fetch-stage sequencer for a 2**ADDRESS_WIDTH x DATA_WIDTH instruction memory
// with a combinational read port. Owns the program counter, presents a
// registered instruction/PC pair to decode, and handles stall, branch redirect
// and halt detection. Before execution the same address port is time-shared
// with a program-load stream that writes instructions sequentially from 0.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   load_start, run_start      mode requests (load_start wins if both)
//   load_valid/load_ready      load handshake: a beat transfers in any cycle
//                              where both are high; load_ready is high only in
//                              LOAD and never depends on load_valid
//   load_data, load_last       beat payload and end-of-program marker
//   stall                      decode back-pressure (hold fetch outputs)
//   branch_taken/_target       redirect fetch (overrides stall)
//   imem_addr/_rdata/_we/_wdata  instruction memory port
//   if_instr, if_pc, if_valid  registered fetch outputs to decode
//   state                      FSM state (IDLE=00 LOAD=01 RUN=10 HALT=11)
//   halted                     high in HALT
//   load_count                 words written by the most recent load
module fetch_controller #(
    parameter int                  DATA_WIDTH    = 20,
    parameter int                  ADDRESS_WIDTH = 8,
    parameter int                  MEM_SIZE      = 256,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD   = 20'hFFFFF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     load_start,
    input  logic                     run_start,
    input  logic                     load_valid,
    input  logic [DATA_WIDTH-1:0]    load_data,
    input  logic                     load_last,
    output logic                     load_ready,
    input  logic                     stall,
    input  logic                     branch_taken,
    input  logic [ADDRESS_WIDTH-1:0] branch_target,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    output logic                     imem_we,
    output logic [DATA_WIDTH-1:0]    imem_wdata,
    output logic [DATA_WIDTH-1:0]    if_instr,
    output logic [ADDRESS_WIDTH-1:0] if_pc,
    output logic                     if_valid,
    output logic [1:0]               state,
    output logic                     halted,
    output logic [ADDRESS_WIDTH:0]   load_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LOAD = 2'b01,
        S_RUN  = 2'b10,
        S_HALT = 2'b11
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(MEM_SIZE - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH:0]   CNT_ONE   = (ADDRESS_WIDTH + 1)'(1);

    state_t                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH:0]   load_count_q, load_count_d;
    logic [DATA_WIDTH-1:0]    if_instr_q, if_instr_d;
    logic [ADDRESS_WIDTH-1:0] if_pc_q, if_pc_d;
    logic                     if_valid_q, if_valid_d;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        wr_ptr_d     = wr_ptr_q;
        load_count_d = load_count_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        if_valid_d   = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (load_start) begin
                    state_d      = S_LOAD;
                    wr_ptr_d     = '0;
                    load_count_d = '0;
                end else if (run_start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            S_LOAD: begin
                if (load_valid) begin
                    wr_ptr_d     = wr_ptr_q + ADDR_ONE;
                    load_count_d = load_count_q + CNT_ONE;
                    // Writing the top address fills memory: the load ends
                    // even without load_last, and wr_ptr wraps harmlessly.
                    if (load_last || (wr_ptr_q == LAST_ADDR)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RUN: begin
                if (branch_taken) begin
                    // Bubble; the word read this cycle is from the wrong
                    // path, so it is neither issued nor halt-checked.
                    pc_d = branch_target;
                end else if (stall) begin
                    if_valid_d = if_valid_q;
                end else if (imem_rdata == HALT_WORD) begin
                    // pc stays on the halt address; HALT_WORD is never issued.
                    state_d = S_HALT;
                end else begin
                    if_instr_d = imem_rdata;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + ADDR_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            pc_q         <= '0;
            wr_ptr_q     <= '0;
            load_count_q <= '0;
            if_instr_q   <= '0;
            if_pc_q      <= '0;
            if_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            wr_ptr_q     <= wr_ptr_d;
            load_count_q <= load_count_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            if_valid_q   <= if_valid_d;
        end
    end

    always_comb begin
        imem_addr = '0;
        case (state_q)
            S_LOAD:        imem_addr = wr_ptr_q;
            S_RUN, S_HALT: imem_addr = pc_q;
            default:       imem_addr = '0;
        endcase
    end

    assign load_ready = (state_q == S_LOAD);
    assign imem_we    = load_valid & load_ready;
    assign imem_wdata = load_ready ? load_data : '0;
    assign halted     = (state_q == S_HALT);
    assign state      = state_q;
    assign load_count = load_count_q;
    assign if_instr   = if_instr_q;
    assign if_pc      = if_pc_q;
    assign if_valid   = if_valid_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: a behavioural 256 x 20 memory with combinational
// read, directed stimulus, and a scoreboard that receives expected {pc, instr}
// pairs for every cycle decode should see a valid fetch.
module tb_fetch_controller;
    localparam int DW = 20;
    localparam int AW = 8;

    logic          clk;
    logic          rst_n;
    logic          load_start, run_start, load_valid, load_last;
    logic [DW-1:0] load_data;
    logic          load_ready;
    logic          stall, branch_taken;
    logic [AW-1:0] branch_target;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          imem_we;
    logic [DW-1:0] imem_wdata;
    logic [DW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic          if_valid;
    logic [1:0]    state;
    logic          halted;
    logic [AW:0]   load_count;

    fetch_controller dut (
        .clk(clk), .rst_n(rst_n),
        .load_start(load_start), .run_start(run_start),
        .load_valid(load_valid), .load_data(load_data), .load_last(load_last),
        .load_ready(load_ready), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_we(imem_we), .imem_wdata(imem_wdata),
        .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid),
        .state(state), .halted(halted), .load_count(load_count)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model; the bench can also poke words through tb_we
    logic [DW-1:0] mem [256] = '{default: '0};
    logic          tb_we;
    logic [AW-1:0] tb_addr;
    logic [DW-1:0] tb_data;
    int            write_total;

    assign imem_rdata = mem[imem_addr];

    initial write_total = 0;
    always @(posedge clk) begin
        if (imem_we) begin
            mem[imem_addr] <= imem_wdata;
            write_total    <= write_total + 1;
        end else if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end
    end

    // scoreboard
    logic [AW+DW-1:0] exp_q[$];
    int checks;
    int errors;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [AW-1:0] pc, input logic [DW-1:0] instr);
        exp_q.push_back({pc, instr});
    endtask

    // monitor: every valid fetch cycle must match the head of the queue
    always @(negedge clk) begin
        if (rst_n && if_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_fetch", {4'h0, if_pc, if_instr}, 32'hFFFFFFFF);
            end else begin
                logic [AW+DW-1:0] e;
                e = exp_q.pop_front();
                check("fetch_pc_instr", {4'h0, if_pc, if_instr}, {4'h0, e});
            end
        end
    end

    // driver tasks
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        tick();
        tb_we = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic last);
        load_valid = 1'b1; load_data = d; load_last = last;
        tick();
        load_valid = 1'b0; load_last = 1'b0;
    endtask

    task automatic start_run();
        run_start = 1'b1;
        tick();
        run_start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, 32'(state), 32'h0);
        check({tag, "_if_valid"}, 32'(if_valid), 32'h0);
        check({tag, "_if_instr"}, 32'(if_instr), 32'h0);
        check({tag, "_if_pc"}, 32'(if_pc), 32'h0);
        check({tag, "_imem_we"}, 32'(imem_we), 32'h0);
        check({tag, "_imem_addr"}, 32'(imem_addr), 32'h0);
        check({tag, "_imem_wdata"}, 32'(imem_wdata), 32'h0);
        check({tag, "_load_ready"}, 32'(load_ready), 32'h0);
        check({tag, "_halted"}, 32'(halted), 32'h0);
        check({tag, "_load_count"}, 32'(load_count), 32'h0);
    endtask

    int w0;

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        load_start = 0; run_start = 0; load_valid = 0; load_last = 0; load_data = '0;
        stall = 0; branch_taken = 0; branch_target = '0;
        tb_we = 0; tb_addr = '0; tb_data = '0;
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---- 4-word program with halt ----
        w0 = write_total;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("load_state", 32'(state), 32'h1);
        check("load_ready_hi", 32'(load_ready), 32'h1);
        beat(20'h00011, 1'b0);
        beat(20'h00022, 1'b0);
        beat(20'h00033, 1'b0);
        beat(20'hFFFFF, 1'b1);
        check("load_count_4", 32'(load_count), 32'd4);
        check("load_done_state", 32'(state), 32'h0);
        check("load_ready_lo", 32'(load_ready), 32'h0);
        check("load_writes_4", 32'(write_total - w0), 32'd4);
        check("mem0", 32'(mem[0]), 32'h00011);
        check("mem3", 32'(mem[3]), 32'hFFFFF);

        // ---- run to halt ----
        push_exp(8'd0, 20'h00011);
        push_exp(8'd1, 20'h00022);
        push_exp(8'd2, 20'h00033);
        start_run();
        tick(4);
        check("halt_state", 32'(state), 32'h3);
        check("halted", 32'(halted), 32'h1);
        check("halt_if_valid", 32'(if_valid), 32'h0);
        check("halt_pc", 32'(imem_addr), 32'h3);

        // ---- stall 3 cycles after first fetch ----
        for (int i = 0; i < 4; i++) push_exp(8'd0, 20'h00011);
        push_exp(8'd1, 20'h00022);
        push_exp(8'd2, 20'h00033);
        start_run();
        tick();
        stall = 1'b1;
        tick(3);
        stall = 1'b0;
        tick(3);
        check("stall_halt_state", 32'(state), 32'h3);

        // ---- branch overrides stall ----
        poke(8'h40, 20'h0ABCD);
        poke(8'h41, 20'hFFFFF);
        push_exp(8'd0, 20'h00011);
        push_exp(8'h40, 20'h0ABCD);
        start_run();
        tick();
        branch_taken = 1'b1; branch_target = 8'h40; stall = 1'b1;
        tick();
        branch_taken = 1'b0; stall = 1'b0;
        check("branch_bubble", 32'(if_valid), 32'h0);
        check("branch_pc", 32'(imem_addr), 32'h40);
        tick(2);
        check("branch_halt_state", 32'(state), 32'h3);
        check("branch_halt_pc", 32'(imem_addr), 32'h41);

        // ---- full 256-word load (load_start wins over run_start) ----
        w0 = write_total;
        load_start = 1'b1; run_start = 1'b1;
        tick();
        load_start = 1'b0; run_start = 1'b0;
        check("load_wins", 32'(state), 32'h1);
        for (int i = 0; i < 256; i++) beat(20'h10000 + 20'(i), 1'b0);
        check("full_count", 32'(load_count), 32'd256);
        check("full_state", 32'(state), 32'h0);
        check("full_ready_lo", 32'(load_ready), 32'h0);
        check("full_writes", 32'(write_total - w0), 32'd256);
        check("mem_ff", 32'(mem[255]), 32'h100FF);

        // ---- run with no halt: pc wraps, then reset mid-RUN ----
        for (int k = 0; k < 258; k++) push_exp(AW'(k % 256), 20'h10000 + 20'(k % 256));
        start_run();
        tick(258);
        #6;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_run");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ---- reset mid-LOAD ----
        w0 = write_total;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        beat(20'h0AAAA, 1'b0);
        beat(20'h0BBBB, 1'b0);
        load_valid = 1'b1; load_data = 20'h0CCCC;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_load");
        tick(2);
        load_valid = 1'b0;
        check("rst_load_writes", 32'(write_total - w0), 32'd2);
        check("partial_mem1", 32'(mem[1]), 32'h0BBBB);
        check("partial_mem2", 32'(mem[2]), 32'h10002);

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
